// File: rtl/alu_exec_unit.sv
// Execution unit: single-cycle logic/arithmetic ops, bit-serial shifts and
// an iterative shift-add multiplier behind a start/busy/done handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] MUL_STEPS = CW'(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t           state, state_next;
  logic [3:0]       op, op_next;
  logic [WIDTH-1:0] work, work_next;     // shift operand, or multiplicand
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] result, result_next;
  logic             zero_r, zero_next;
  logic             done_r, done_next;

  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mul_sum;
  logic [SHW-1:0]   shamt;

  assign shamt = srcB[SHW-1:0];

  always_comb begin
    single_res = '0;
    case (aluControl)
      OP_AND:  single_res = srcA & srcB;
      OP_OR:   single_res = srcA | srcB;
      OP_ADD:  single_res = srcA + srcB;
      OP_SUB:  single_res = srcA - srcB;
      OP_SLT:  single_res = ($signed(srcA) < $signed(srcB)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      // a zero-distance shift completes immediately with the operand unchanged
      OP_SLL, OP_SRL, OP_SRA: single_res = srcA;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    shifted = work;
    case (op)
      OP_SLL:  shifted = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shifted = work;
    endcase
  end

  assign mul_sum = acc + (mplier[0] ? work : '0);

  always_comb begin
    state_next  = state;
    op_next     = op;
    work_next   = work;
    mplier_next = mplier;
    acc_next    = acc;
    cnt_next    = cnt;
    result_next = result;
    zero_next   = zero_r;
    done_next   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          op_next = aluControl;
          if ((aluControl == OP_SLL || aluControl == OP_SRL || aluControl == OP_SRA) &&
              (shamt != '0)) begin
            work_next  = srcA;
            cnt_next   = {1'b0, shamt};
            state_next = SHIFT;
          end else if (aluControl == OP_MUL) begin
            work_next   = srcA;
            mplier_next = srcB;
            acc_next    = '0;
            cnt_next    = MUL_STEPS;
            state_next  = MUL;
          end else begin
            result_next = single_res;
            zero_next   = (single_res == '0);
            done_next   = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_next = shifted;
        cnt_next  = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          result_next = shifted;
          zero_next   = (shifted == '0);
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      MUL: begin
        acc_next    = mul_sum;
        work_next   = {work[WIDTH-2:0], 1'b0};
        mplier_next = {1'b0, mplier[WIDTH-1:1]};
        cnt_next    = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          result_next = mul_sum;
          zero_next   = (mul_sum == '0);
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op     <= '0;
      work   <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zero_r <= 1'b1;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      op     <= op_next;
      work   <= work_next;
      mplier <= mplier_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      result <= result_next;
      zero_r <= zero_next;
      done_r <= done_next;
    end
  end

  // busy covers the multi-cycle states only, so it never overlaps done
  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign aluResult = result;
  assign zero      = zero_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  aluControl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] aluResult;
  logic        zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_result = 32'h0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .aluControl(aluControl),
    .srcA      (srcA),
    .srcB      (srcB),
    .busy      (busy),
    .done      (done),
    .aluResult (aluResult),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ref_result(input logic [3:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    int n;
    n = int'(b[4:0]);
    case (code)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd6: r = a - b;
      4'd3: r = a << n;
      4'd4: r = a >> n;
      4'd5: r = $signed(a) >>> n;
      4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: r = a * b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [3:0] code, input logic [31:0] b);
    if (code == 4'd3 || code == 4'd4 || code == 4'd5) return int'(b[4:0]);
    if (code == 4'd8) return 32;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one operation at the current mid-cycle point; returns in the done cycle.
  task automatic do_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       input bit spam);
    logic [31:0] exp_r;
    int exp_k;
    int cycles;
    exp_r = ref_result(code, a, b);
    exp_k = ref_latency(code, b);
    start = 1'b1; aluControl = code; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      chk("busy_while_running", {31'b0, busy}, 32'd1);
      chk("result_held", aluResult, last_result);
      if (spam) begin
        start = 1'($urandom_range(0, 1));
        aluControl = 4'($urandom);
        srcA = $urandom;
        srcB = $urandom;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    chk("latency", 32'(cycles), 32'(exp_k));
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_low_at_done", {31'b0, busy}, 32'd0);
    chk("result", aluResult, exp_r);
    chk("zero", {31'b0, zero}, {31'b0, (exp_r == 32'd0)});
    $display("op code=%h a=%h b=%h result=%h cycles=%0d", code, a, b, aluResult, cycles);
    last_result = exp_r;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_hold", aluResult, last_result);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; aluControl = 4'd0; srcA = 32'd0; srcB = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", aluResult, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;

    do_op(4'b0010, 32'hFFFFFFFF, 32'd1, 1'b0);
    chk("add_wrap", aluResult, 32'h0);
    idle_check();
    do_op(4'b0110, 32'd5, 32'd7, 1'b0);
    chk("sub_neg", aluResult, 32'hFFFFFFFE);
    do_op(4'b0111, 32'hFFFFFFFF, 32'd0, 1'b0);
    chk("slt_signed", aluResult, 32'd1);
    do_op(4'b0101, 32'h80000000, 32'd4, 1'b0);
    chk("sra_4", aluResult, 32'hF8000000);
    idle_check();
    do_op(4'b0011, 32'h12345678, 32'd0, 1'b0);
    chk("sll_0", aluResult, 32'h12345678);
    do_op(4'b1000, 32'h00010001, 32'h00010001, 1'b1);
    chk("mul_spec", aluResult, 32'h00020001);
    idle_check();
    do_op(4'b0100, 32'h80000000, 32'd31, 1'b1);
    do_op(4'b0011, 32'hFFFFFFFF, 32'h0000001F, 1'b0);
    do_op(4'b1111, 32'h1234, 32'h5678, 1'b0);
    idle_check();

    // back-to-back: second start issued in the first op's done cycle
    do_op(4'b0000, 32'h0000F0F0, 32'h00000FF0, 1'b0);
    chk("b2b_and", aluResult, 32'h000000F0);
    do_op(4'b0001, 32'h00000F00, 32'h000000F0, 1'b0);
    chk("b2b_or", aluResult, 32'h00000FF0);
    idle_check();

    // reset during a multiply aborts it without a done pulse
    start = 1'b1; aluControl = 4'b1000; srcA = 32'h00010001; srcB = 32'h00010001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_result", aluResult, 32'd0);
    chk("abort_zero", {31'b0, zero}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    last_result = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", {31'b0, done}, 32'd0);
    end
    do_op(4'b0010, 32'd2, 32'd3, 1'b0);
    chk("add_after_reset", aluResult, 32'd5);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_op(c, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
